// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: captures {frame_err, byte} from the UART receiver into a
// first-word-fall-through FIFO, with threshold / idle-timeout / overrun interrupt.
module uart_rx_fifo #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned THRESH  = 6,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          rx_frame_err,
  output logic          rx_ack,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_err,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overrun,
  input  logic          clr_overrun,
  output logic          irq
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_THR  = (AW + 1)'(THRESH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  logic          r_ack;
  logic          r_ovr;
  logic [CW-1:0] r_cnt;
  logic          r_irq;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_tmo;
  logic [8:0]    w_head;

  always_comb begin
    w_empty = (r_level == '0);
    w_full  = (r_level == LVL_FULL);
    w_pop   = rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a push is accepted even at full.
    w_push  = rx_valid && (!w_full || w_pop);
    w_drop  = rx_valid && !w_push;
    w_tmo   = (r_cnt == CNT_MAX);
    w_head  = r_mem[r_rp];
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem[r_wp] <= {rx_frame_err, rx_data};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + (AW + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_ovr <= 1'b0;
      r_cnt <= '0;
      r_irq <= 1'b0;
    end else begin
      r_ack <= rx_valid;
      if (w_drop) begin
        r_ovr <= 1'b1;
      end else if (clr_overrun) begin
        r_ovr <= 1'b0;
      end
      if (w_push || w_pop || w_empty) begin
        r_cnt <= '0;
      end else if (!w_tmo) begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_irq <= (r_level >= LVL_THR) | w_tmo | r_ovr;
    end
  end

  always_comb begin
    rx_ack  = r_ack;
    rd_data = w_empty ? '0 : w_head[7:0];
    rd_err  = w_empty ? 1'b0 : w_head[8];
    empty   = w_empty;
    full    = w_full;
    level   = r_level;
    overrun = r_ovr;
    irq     = r_irq;
  end

endmodule
